// File: rtl/rng_gen_2.sv
// rng_gen_2: XORed ring oscillators -> 2-flop sync -> decimator -> von Neumann -> WIDTH-bit packer
// with a valid/ready output. Optional repetition-count health test when RNG_HEALTH_EN is defined.

module osc_ring_3 (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic osc_out
);
   // Clocked Johnson-ring stand-in for the free-running 3-stage oscillator
   logic [2:0] ring;
   always_ff @(posedge clk) begin
      if (rst)         ring <= '0;
      else if (enable) ring <= {ring[1:0], ~ring[2]};
   end
   assign osc_out = ring[2];
endmodule

module osc_ring_5 (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic osc_out
);
   logic [4:0] ring;
   always_ff @(posedge clk) begin
      if (rst)         ring <= '0;
      else if (enable) ring <= {ring[3:0], ~ring[4]};
   end
   assign osc_out = ring[4];
endmodule

module osc_ring_7 (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic osc_out
);
   logic [6:0] ring;
   always_ff @(posedge clk) begin
      if (rst)         ring <= '0;
      else if (enable) ring <= {ring[5:0], ~ring[6]};
   end
   assign osc_out = ring[6];
endmodule

module osc_ring_9 (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic osc_out
);
   logic [8:0] ring;
   always_ff @(posedge clk) begin
      if (rst)         ring <= '0;
      else if (enable) ring <= {ring[7:0], ~ring[8]};
   end
   assign osc_out = ring[8];
endmodule

module rng_gen_2 #(
   parameter int NUM_OSC   = 4,
   parameter int WIDTH     = 32,
   parameter int DECIM     = 4,
   parameter int REP_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             health_fail
);
   localparam int         CW       = $clog2(WIDTH + 1);
   localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

   logic [3:0]       osc;
   logic             raw;
   logic             s1, s2;
   logic [7:0]       dcnt;
   logic             phase, first;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic             d_take, emit, full, xfer;

   osc_ring_3 u_osc3 (.clk(clk), .rst(rst), .enable(enable), .osc_out(osc[0]));

   generate
      if (NUM_OSC >= 2) begin : g_osc5
         osc_ring_5 u_osc5 (.clk(clk), .rst(rst), .enable(enable), .osc_out(osc[1]));
      end else begin : g_no_osc5
         assign osc[1] = 1'b0;
      end
      if (NUM_OSC >= 3) begin : g_osc7
         osc_ring_7 u_osc7 (.clk(clk), .rst(rst), .enable(enable), .osc_out(osc[2]));
      end else begin : g_no_osc7
         assign osc[2] = 1'b0;
      end
      if (NUM_OSC >= 4) begin : g_osc9
         osc_ring_9 u_osc9 (.clk(clk), .rst(rst), .enable(enable), .osc_out(osc[3]));
      end else begin : g_no_osc9
         assign osc[3] = 1'b0;
      end
   endgenerate

   assign raw = ^osc;

   always_comb begin
      d_take = enable && (dcnt == DEC_LAST);
      // second half of a pair with differing bits: 10 emits 1, 01 emits 0, i.e. the first bit
      emit   = d_take && phase && (first != s2);
      full   = (bit_cnt == CW'(WIDTH));
      xfer   = enable && full && (!valid || ready) && !health_fail;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         dcnt     <= '0;
         phase    <= 1'b0;
         first    <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         data_out <= '0;
         valid    <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;

         if (valid && ready) valid <= 1'b0;
         if (xfer) begin
            data_out <= shreg;
            valid    <= 1'b1;
         end

         if (!enable) begin
            dcnt    <= '0;
            phase   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
         end else begin
            dcnt <= d_take ? '0 : dcnt + 8'd1;
            if (d_take) begin
               if (!phase) begin
                  first <= s2;
                  phase <= 1'b1;
               end else begin
                  phase <= 1'b0;
               end
            end
            // a transfer empties the slot and drops any bit emitted on the same edge
            if (xfer) begin
               shreg   <= '0;
               bit_cnt <= '0;
            end else if (emit && !full) begin
               shreg   <= {shreg[WIDTH-2:0], first};
               bit_cnt <= bit_cnt + CW'(1);
            end
         end
      end
   end

`ifdef RNG_HEALTH_EN
   localparam logic [7:0] REP_L = 8'(REP_LIMIT);
   logic [7:0] run;
   logic       prev_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         run         <= '0;
         prev_d      <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         if (run >= REP_L) health_fail <= 1'b1;
         if (!enable) begin
            run <= '0;
         end else if (d_take) begin
            prev_d <= s2;
            if (run == 8'd0 || s2 != prev_d) run <= 8'd1;
            else if (run != 8'hFF)            run <= run + 8'd1;
         end
      end
   end
`else
   // constant 0 for every legal REP_LIMIT
   assign health_fail = (REP_LIMIT == 0);
`endif

endmodule

// File: tb/tb_rng_gen_2.sv
// Directed bench for rng_gen_2 (WIDTH=8, DECIM=1): forces the raw XOR net with chosen bit streams.
// Health-test steps adapt their expectations when RNG_HEALTH_EN is defined.

module tb_rng_gen_2;
   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       ready;
   logic [7:0] data_out;
   logic       valid;
   logic       health_fail;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

`ifdef RNG_HEALTH_EN
   localparam bit HEALTH = 1'b1;
`else
   localparam bit HEALTH = 1'b0;
`endif

   rng_gen_2 #(.NUM_OSC(4), .WIDTH(8), .DECIM(1), .REP_LIMIT(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .data_out(data_out),
      .valid(valid), .ready(ready), .health_fail(health_fail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // one sample per cycle: drive now (at a negedge), return after the next posedge
   task automatic cyc(input logic en, input logic b);
      enable = en;
      if (b) force dut.raw = 1'b1;
      else   force dut.raw = 1'b0;
      @(negedge clk);
   endtask

   task automatic pair(input logic a, input logic b);
      cyc(1'b1, a);
      cyc(1'b1, b);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin
         if (w[i]) pair(1'b1, 1'b0);
         else      pair(1'b0, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; ready = 1'b0;
      force dut.raw = 1'b0;
      @(negedge clk);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_data", 64'(data_out), 64'h0);
      chk("rst_health", 64'(health_fail), 64'd0);
      chk("rst_cnt", 64'(dut.bit_cnt), 64'd0);

      // alternating 1,0: eight "10" pairs
      for (int i = 0; i < 8; i++) pair(1'b1, 1'b0);
      pair(1'b0, 1'b0);
      chk("t1_cnt_full", 64'(dut.bit_cnt), 64'd8);
      chk("t1_valid_lat", 64'(valid), 64'd0);
      pair(1'b0, 1'b0);
      chk("t1_valid", 64'(valid), 64'd1);
      chk("t1_data", 64'(data_out), 64'hFF);
      chk("t1_cnt_clr", 64'(dut.bit_cnt), 64'd0);

      // 01,10,00,11,01 -> bits 0,1,0
      ready = 1'b1;
      pair(1'b0, 1'b1); pair(1'b1, 1'b0); pair(1'b0, 1'b0);
      pair(1'b1, 1'b1); pair(1'b0, 1'b1); pair(1'b0, 1'b0);
      chk("t2_cnt", 64'(dut.bit_cnt), 64'd3);
      chk("t2_bits", 64'(dut.shreg[2:0]), 64'h2);
      chk("t2_valid_drop", 64'(valid), 64'd0);
      ready = 1'b0;

      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      send_word(8'hA5);
      send_word(8'h3C);
      pair(1'b1, 1'b0); pair(1'b1, 1'b0);
      pair(1'b0, 1'b0); pair(1'b0, 1'b0);
      chk("t3_hold_data", 64'(data_out), 64'hA5);
      chk("t3_hold_valid", 64'(valid), 64'd1);
      chk("t3_pending_cnt", 64'(dut.bit_cnt), 64'd8);
      chk("t3_pending_word", 64'(dut.shreg), 64'h3C);
      ready = 1'b1;
      cyc(1'b1, 1'b0);
      ready = 1'b0;
      cyc(1'b1, 1'b0);
      chk("t3_swap_data", 64'(data_out), 64'h3C);
      chk("t3_swap_valid", 64'(valid), 64'd1);
      chk("t3_swap_cnt", 64'(dut.bit_cnt), 64'd0);

      // five bits 1,1,0,1,0 then enable drop
      pair(1'b1, 1'b0); pair(1'b1, 1'b0); pair(1'b0, 1'b1);
      pair(1'b1, 1'b0); pair(1'b0, 1'b1); pair(1'b0, 1'b0);
      chk("t4_cnt5", 64'(dut.bit_cnt), 64'd5);
      chk("t4_bits5", 64'(dut.shreg[4:0]), 64'h1A);
      cyc(1'b0, 1'b0);
      chk("t4_cnt_clr", 64'(dut.bit_cnt), 64'd0);
      chk("t4_valid_keep", 64'(valid), 64'd1);
      chk("t4_data_keep", 64'(data_out), 64'h3C);

      rst = 1'b1;
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      chk("t5_valid", 64'(valid), 64'd0);
      chk("t5_data", 64'(data_out), 64'h0);

      // raw held at 1: d = 0,0 then a run of 1s
      for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1);
      chk("t6_health_pre", 64'(health_fail), 64'd0);
      cyc(1'b1, 1'b1);
      chk("t6_health", 64'(health_fail), 64'(HEALTH));
      cyc(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) pair(1'b1, 1'b0);
      pair(1'b0, 1'b0); pair(1'b0, 1'b0);
      chk("t6_health_sticky", 64'(health_fail), 64'(HEALTH));
      chk("t6_valid", 64'(valid), HEALTH ? 64'd0 : 64'd1);
      chk("t6_data", 64'(data_out), HEALTH ? 64'h0 : 64'hFF);

      release dut.raw;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
